// File: rtl/mmio_uart_tx_if.sv
// Data-memory style responder bus for the memory-mapped UART transmitter.
//   w_en       : byte write enables from the core store path (lane 0 = [7:0])
//   address    : byte address, decoded on [15:2]
//   write_data : store data
//   read_data  : registered read data for the previous-cycle address
//   hit        : registered; previous-cycle address fell in the UART map
interface mmio_uart_tx_if;
    logic [3:0]  w_en;
    logic [15:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;

    modport master (
        output w_en,
        output address,
        output write_data,
        input  read_data,
        input  hit
    );

    modport slave (
        input  w_en,
        input  address,
        input  write_data,
        output read_data,
        output hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Stores to TXDATA push bytes into a small TX FIFO; a bit-timing FSM
// serializes them LSB first on tx. STATUS reports full/empty/busy/
// overflow/count; read data and hit are registered (SRAM-like 1-cycle read).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : responder side of the data-memory bus (mmio_uart_tx_if.slave)
//   tx   : serial output, idle high
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    mmio_uart_tx_if.slave       bus,
    output logic                tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Registers
    state_t            r_state;
    logic [CNT_W-1:0]  r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_overflow;
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [31:0]       r_read_data;
    logic              r_hit;

    // Combinational next-state / control
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_baud_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_tx_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_push_req;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic              w_bit_done;
    logic              w_txdata_sel;
    logic              w_status_sel;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic [PTR_W:0]    w_count;
    logic [7:0]        w_head;
    logic [31:0]       w_status;
    logic              w_unused;

    // Address decode on the word address
    assign w_txdata_sel = (bus.address[15:2] == BASE_ADDR[15:2]);
    assign w_status_sel = (bus.address[15:2] == STATUS_ADDR[15:2]);

    // FIFO flags: pointers carry one extra wrap bit to tell full from empty
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_busy  = (r_state != S_IDLE);

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands
    assign w_push_req = w_txdata_sel && bus.w_en[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_status_sel && bus.w_en[0] && bus.write_data[3];

    assign w_status = {24'd0, 4'(w_count), r_overflow, w_busy, w_empty, w_full};

    assign w_bit_done = (r_baud == CNT_W'(CLKS_PER_BIT - 1));

    assign w_unused = ^{bus.address[1:0], bus.write_data[31:8]};

    // Serializer FSM next-state and datapath
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                    w_state_nxt   = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + CNT_W'(1);
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, FIFO pointers, flags and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_tx        <= 1'b1;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_read_data <= 32'd0;
            r_hit       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
            // Set wins over a same-cycle clear
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_hit       <= w_txdata_sel || w_status_sel;
            r_read_data <= w_status_sel ? w_status : 32'd0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= bus.write_data[7:0];
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.hit       = r_hit;
    assign tx            = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

    localparam int unsigned CPB = 4;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] STAT = 16'hFF04;

    logic clk;
    logic rst;
    logic tx;
    int   n_checks;
    int   n_pass;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] wen);
        bus.address    = addr;
        bus.write_data = data;
        bus.w_en       = wen;
        @(posedge clk);
        @(negedge clk);
        bus.w_en       = 4'b0000;
        bus.write_data = 32'd0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data,
                            output logic hit);
        bus.address = addr;
        bus.w_en    = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        data = bus.read_data;
        hit  = bus.hit;
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        bus.w_en       = 4'b0000;
        bus.address    = 16'h0000;
        bus.write_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Watch one frame on tx starting at frame cycle first_i; STATUS is held on
    // the bus so read_data shows the state one cycle behind.
    task automatic check_frame(input logic [7:0] data, input int first_i,
                               input string nm, output logic [31:0] st0,
                               output logic [31:0] st1, output logic [31:0] st20);
        int   errs;
        int   bad_i;
        int   b;
        logic exp_b;
        logic bad_act;
        logic bad_exp;
        errs = 0; bad_i = -1; bad_act = 1'bx; bad_exp = 1'bx;
        st0 = 'x; st1 = 'x; st20 = 'x;
        bus.address = STAT;
        bus.w_en    = 4'b0000;
        for (int i = first_i; i < 40; i++) begin
            @(negedge clk);
            b = i / int'(CPB);
            if (b == 0)      exp_b = 1'b0;
            else if (b == 9) exp_b = 1'b1;
            else             exp_b = data[b-1];
            if (tx !== exp_b) begin
                if (errs == 0) begin
                    bad_i = i; bad_act = tx; bad_exp = exp_b;
                end
                errs++;
            end
            if (i == 0)  st0  = bus.read_data;
            if (i == 1)  st1  = bus.read_data;
            if (i == 20) st20 = bus.read_data;
        end
        n_checks++;
        if (errs != 0)
            $display("FAIL %s frame: cycle %0d tx=%b expected %b (%0d bad cycles)",
                     nm, bad_i, bad_act, bad_exp, errs);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        h;
        apply_reset();
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
        else n_pass++;
        n_checks++;
        if (bus.hit !== 1'b0) $display("FAIL reset_hit: got %b expected 0", bus.hit);
        else n_pass++;
        n_checks++;
        if (bus.read_data !== 32'd0)
            $display("FAIL reset_rdata: got %h expected 00000000", bus.read_data);
        else n_pass++;
        bus_read(STAT, rd, h);
        n_checks++;
        if (rd !== 32'h0000_0002 || h !== 1'b1)
            $display("FAIL reset_status: got %h hit %b expected 00000002 hit 1", rd, h);
        else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [31:0] s0, s1, s20;
        apply_reset();
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        check_frame(8'hA5, 0, "single", s0, s1, s20);
        n_checks++;
        if (s0 !== 32'h0000_0010) $display("FAIL single_st_queued: got %h expected 00000010", s0);
        else n_pass++;
        n_checks++;
        if (s1 !== 32'h0000_0006) $display("FAIL single_st_busy: got %h expected 00000006", s1);
        else n_pass++;
        n_checks++;
        if (s20 !== 32'h0000_0006) $display("FAIL single_st_mid: got %h expected 00000006", s20);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.read_data !== 32'h0000_0006)
            $display("FAIL single_busy_last: got %h expected 00000006", bus.read_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.read_data !== 32'h0000_0002 || tx !== 1'b1)
            $display("FAIL single_idle: got %h tx %b expected 00000002 tx 1", bus.read_data, tx);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] s0, s1, s20;
        apply_reset();
        bus_write(BASE, 32'h0000_0001, 4'b0001);
        bus_write(BASE, 32'h0000_0002, 4'b0001);
        bus_write(BASE, 32'h0000_0003, 4'b0001);
        check_frame(8'h01, 2, "b2b_1", s0, s1, s20);
        n_checks++;
        if (s20 !== 32'h0000_0024) $display("FAIL b2b_count2: got %h expected 00000024", s20);
        else n_pass++;
        check_frame(8'h02, 0, "b2b_2", s0, s1, s20);
        n_checks++;
        if (s20 !== 32'h0000_0014) $display("FAIL b2b_count1: got %h expected 00000014", s20);
        else n_pass++;
        check_frame(8'h03, 0, "b2b_3", s0, s1, s20);
        n_checks++;
        if (s20 !== 32'h0000_0006) $display("FAIL b2b_count0: got %h expected 00000006", s20);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.read_data !== 32'h0000_0002)
            $display("FAIL b2b_idle: got %h expected 00000002", bus.read_data);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic        h;
        apply_reset();
        for (int i = 0; i < 6; i++) bus_write(BASE, 32'h10 + 32'(i), 4'b0001);
        bus_read(STAT, rd, h);
        n_checks++;
        if (rd !== 32'h0000_004D) $display("FAIL ovf_status: got %h expected 0000004d", rd);
        else n_pass++;
        bus_write(STAT, 32'h0000_0008, 4'b0001);
        bus_read(STAT, rd, h);
        n_checks++;
        if (rd !== 32'h0000_0045) $display("FAIL ovf_clear: got %h expected 00000045", rd);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic        h;
        apply_reset();
        bus_write(BASE, 32'h0000_5500, 4'b0010);
        bus_read(STAT, rd, h);
        n_checks++;
        if (rd !== 32'h0000_0002) $display("FAIL lane_no_push: got %h expected 00000002", rd);
        else n_pass++;
        bus_read(16'h1000, rd, h);
        n_checks++;
        if (rd !== 32'd0 || h !== 1'b0)
            $display("FAIL miss_1000: got %h hit %b expected 00000000 hit 0", rd, h);
        else n_pass++;
        bus_read(BASE, rd, h);
        n_checks++;
        if (rd !== 32'd0 || h !== 1'b1)
            $display("FAIL txdata_read: got %h hit %b expected 00000000 hit 1", rd, h);
        else n_pass++;
        bus_read(16'hFF07, rd, h);
        n_checks++;
        if (rd !== 32'h0000_0002 || h !== 1'b1)
            $display("FAIL status_ff07: got %h hit %b expected 00000002 hit 1", rd, h);
        else n_pass++;
        bus_read(16'hFF08, rd, h);
        n_checks++;
        if (rd !== 32'd0 || h !== 1'b0)
            $display("FAIL miss_ff08: got %h hit %b expected 00000000 hit 0", rd, h);
        else n_pass++;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL decode_tx_idle: got %b expected 1", tx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic        h;
        int          errs;
        apply_reset();
        bus_write(BASE, 32'h0000_0000, 4'b0001);
        bus_write(BASE, 32'h0000_0000, 4'b0001);
        bus_write(BASE, 32'h0000_0000, 4'b0001);
        repeat (16) @(negedge clk);
        // frame cycle 17: data bit 3 of 8'h00
        n_checks++;
        if (tx !== 1'b0) $display("FAIL mid_bit3: got %b expected 0", tx);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL mid_rst_tx: got %b expected 1", tx);
        else n_pass++;
        bus_read(STAT, rd, h);
        n_checks++;
        if (rd !== 32'h0000_0002) $display("FAIL mid_rst_status: got %h expected 00000002", rd);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL mid_rst_quiet: got %0d low cycles expected 0", errs);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.w_en = 4'b0000;
        bus.address    = 16'h0000;
        bus.write_data = 32'd0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_decode();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
